// File: rtl/pos_cell_rd_ctrl_if.sv
// Bundle of the read-stream client, write client and cell RAM port signals
// seen by pos_cell_rd_ctrl. The controller uses "slave", the environment uses "master".
interface pos_cell_rd_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_start;
    logic                  rd_stall;
    logic                  rd_busy;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_pid;
    logic [DATA_WIDTH-1:0] rd_pos;
    logic                  rd_done;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] cell_count;
    logic                  cnt_err;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_rden;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  rd_start, rd_stall, wr_valid, wr_addr, wr_data, ram_q,
        output rd_busy, rd_valid, rd_pid, rd_pos, rd_done, wr_ready,
               cell_count, cnt_err, ram_address, ram_data, ram_rden, ram_wren
    );

    modport master (
        output rd_start, rd_stall, wr_valid, wr_addr, wr_data, ram_q,
        input  rd_busy, rd_valid, rd_pid, rd_pos, rd_done, wr_ready,
               cell_count, cnt_err, ram_address, ram_data, ram_rden, ram_wren
    );
endinterface

// File: rtl/pos_cell_rd_ctrl.sv
// Shares one single-port cell position RAM (2-cycle read latency) between a
// whole-cell read stream and position/count write-back.
module pos_cell_rd_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic            clk,
    input  logic            rst_n,
    pos_cell_rd_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO_D  = {DATA_WIDTH{1'b0}};

    state_t                state_r, next_s;
    logic                  rd_pend_r, rd_pend_next_s;
    logic                  wait_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] count_r;
    logic [ADDR_WIDTH-1:0] cell_count_r;
    logic                  cnt_err_r;
    logic                  v0_r, v1_r, last0_r, last1_r;
    logic [ADDR_WIDTH-1:0] pid0_r, pid1_r;

    logic                  busy_s, start_acc_s, wr_ready_s, wr_acc_s, pend_eff_s;
    logic                  cnt_ret_s, cnt_over_s, issue_s, last_issue_s, zero_done_s;
    logic [ADDR_WIDTH-1:0] raw_cnt_s, cnt_clamp_s;

    // Request bookkeeping, write arbitration and count-return decode.
    always_comb begin
        busy_s       = (state_r != ST_IDLE) || rd_pend_r;
        start_acc_s  = bus.rd_start && !busy_s;
        wr_ready_s   = rst_n && (state_r == ST_IDLE) && !rd_pend_r;
        wr_acc_s     = bus.wr_valid && wr_ready_s;
        pend_eff_s   = rd_pend_r || start_acc_s;
        raw_cnt_s    = bus.ram_q[ADDR_WIDTH-1:0];
        cnt_over_s   = (raw_cnt_s > MAX_CNT);
        cnt_clamp_s  = cnt_over_s ? MAX_CNT : raw_cnt_s;
        cnt_ret_s    = (state_r == ST_WAIT_CNT) && wait_r;
        zero_done_s  = cnt_ret_s && (cnt_clamp_s == ZERO_A);
        issue_s      = (state_r == ST_STREAM) && !bus.rd_stall;
        last_issue_s = issue_s && (addr_r == count_r);
    end

    // Next-state and pending-request update.
    always_comb begin
        next_s         = state_r;
        rd_pend_next_s = rd_pend_r;
        case (state_r)
            ST_IDLE: begin
                // A request arriving this very cycle can launch at once unless a write takes the port.
                if (pend_eff_s && !wr_acc_s) begin
                    next_s         = ST_RD_CNT;
                    rd_pend_next_s = 1'b0;
                end else if (start_acc_s) begin
                    rd_pend_next_s = 1'b1;
                end else begin
                    rd_pend_next_s = rd_pend_r;
                end
            end
            ST_RD_CNT: next_s = ST_WAIT_CNT;
            ST_WAIT_CNT: begin
                if (!wait_r) begin
                    next_s = ST_WAIT_CNT;
                end else if (zero_done_s) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_issue_s) begin
                    next_s = ST_DRAIN;
                end else begin
                    next_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (v1_r && last1_r) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DRAIN;
                end
            end
            default: begin
                next_s         = ST_IDLE;
                rd_pend_next_s = 1'b0;
            end
        endcase
    end

    // State register and count-wait phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rd_pend_r <= 1'b0;
            wait_r    <= 1'b0;
        end else begin
            state_r   <= next_s;
            rd_pend_r <= rd_pend_next_s;
            wait_r    <= (state_r == ST_WAIT_CNT) && !wait_r;
        end
    end

    // Stream address, latched count, visible cell count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= ZERO_A;
            count_r      <= ZERO_A;
            cell_count_r <= ZERO_A;
            cnt_err_r    <= 1'b0;
        end else begin
            if (cnt_ret_s) begin
                count_r <= cnt_clamp_s;
                addr_r  <= ONE_A;
            end else if (issue_s) begin
                addr_r  <= addr_r + ONE_A;
            end else begin
                addr_r  <= addr_r;
            end
            if (wr_acc_s && (bus.wr_addr == ZERO_A)) begin
                cell_count_r <= bus.wr_data[ADDR_WIDTH-1:0];
            end else if (cnt_ret_s) begin
                cell_count_r <= cnt_clamp_s;
            end else begin
                cell_count_r <= cell_count_r;
            end
            cnt_err_r <= cnt_err_r || (cnt_ret_s && cnt_over_s);
        end
    end

    // Two-stage tracker aligned with the RAM read latency; stall never holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r    <= 1'b0;
            v1_r    <= 1'b0;
            last0_r <= 1'b0;
            last1_r <= 1'b0;
            pid0_r  <= ZERO_A;
            pid1_r  <= ZERO_A;
        end else begin
            v0_r    <= issue_s;
            last0_r <= last_issue_s;
            pid0_r  <= addr_r;
            v1_r    <= v0_r;
            last1_r <= last0_r;
            pid1_r  <= pid0_r;
        end
    end

    // Client-facing outputs.
    always_comb begin
        bus.rd_busy    = busy_s;
        bus.rd_valid   = v1_r;
        bus.rd_pid     = v1_r ? pid1_r : ZERO_A;
        bus.rd_pos     = v1_r ? bus.ram_q : ZERO_D;
        bus.rd_done    = (v1_r && last1_r) || zero_done_s;
        bus.wr_ready   = wr_ready_s;
        bus.cell_count = cell_count_r;
        bus.cnt_err    = cnt_err_r;
    end

    // RAM port drive: writes own the port in IDLE, reads elsewhere.
    always_comb begin
        bus.ram_address = ZERO_A;
        bus.ram_data    = ZERO_D;
        bus.ram_rden    = 1'b0;
        bus.ram_wren    = wr_acc_s;
        case (state_r)
            ST_IDLE: begin
                if (rst_n) begin
                    bus.ram_address = bus.wr_addr;
                    bus.ram_data    = bus.wr_data;
                end else begin
                    bus.ram_address = ZERO_A;
                    bus.ram_data    = ZERO_D;
                end
            end
            ST_RD_CNT: begin
                bus.ram_rden = 1'b1;
            end
            ST_STREAM: begin
                bus.ram_address = addr_r;
                bus.ram_rden    = issue_s;
            end
            default: begin
                bus.ram_address = ZERO_A;
                bus.ram_rden    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pos_cell_rd_ctrl.sv
// Bench for pos_cell_rd_ctrl: RAM model with 2-cycle latency, queue-based
// stream expectation built from the bench's own copy of the RAM contents.
module tb_pos_cell_rd_ctrl;
    localparam int DW   = 96;
    localparam int AW   = 8;
    localparam int PN   = 220;
    localparam int MAXC = PN - 1;

    typedef struct {
        bit            vld;
        logic [AW-1:0] pid;
        logic [DW-1:0] pos;
        bit            last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pos_cell_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    pos_cell_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] q1, q2;
    assign bus.ram_q = q2;

    // RAM: write in the request cycle, read data two cycles later, garbage otherwise.
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        q1 <= bus.ram_rden ? mem[bus.ram_address] : {$urandom, $urandom, $urandom};
        q2 <= q1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t exp_q[$];
    bit    exp_err = 1'b0;
    int    exp_cnt = 0;
    int    n_pass = 0, n_total = 0;
    int    done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, beats = 0, rden_win = 0;
    int    start_cyc = 0, start_done = 0;
    bit    win_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
        int c;
        beat_t e;
        c = int'(ref_mem[0][AW-1:0]);
        if (c > MAXC) begin
            c = MAXC;
            exp_err = 1'b1;
        end
        exp_cnt = c;
        if (c == 0) begin
            e.vld = 1'b0; e.pid = '0; e.pos = '0; e.last = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int p = 1; p <= c; p++) begin
                e.vld = 1'b1; e.pid = AW'(p); e.pos = ref_mem[p]; e.last = (p == c);
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard: every valid/done cycle must match the next expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (win_on && bus.ram_rden) rden_win++;
            if (rst_n && (bus.rd_valid || bus.rd_done)) begin
                if (bus.rd_valid) begin
                    beats++;
                    if (first_vld_cyc < 0) first_vld_cyc = cyc;
                end
                if (bus.rd_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 128'({bus.rd_valid, bus.rd_done}), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_valid", 128'(bus.rd_valid), 128'(e.vld));
                    if (e.vld) begin
                        chk("beat_pid", 128'(bus.rd_pid), 128'(e.pid));
                        chk("beat_pos", 128'(bus.rd_pos), 128'(e.pos));
                    end
                    chk("beat_done", 128'(bus.rd_done), 128'(e.last));
                end
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        chk("wr_ready", 128'(bus.wr_ready), 128'(1));
        ref_mem[a] = d;
        step();
        bus.wr_valid = 1'b0;
        if (a == '0) chk("cell_count_wr", 128'(bus.cell_count), 128'(d[AW-1:0]));
    endtask

    task automatic arm();
        start_cyc = cyc; start_done = done_cnt; first_vld_cyc = -1; beats = 0;
    endtask

    task automatic start_read();
        bus.rd_start = 1'b1;
        push_stream();
        arm();
        step();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start_done) break;
            if (rnd) bus.rd_stall = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.rd_stall = 1'b0;
        if (done_cnt == start_done) chk("done_timeout", 128'(done_cnt - start_done), 128'(1));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_ctrl"}, 128'({bus.rd_busy, bus.rd_valid, bus.rd_pid, bus.rd_done, bus.wr_ready,
                                   bus.cell_count, bus.cnt_err, bus.ram_rden, bus.ram_wren,
                                   bus.ram_address}), 128'(0));
        chk({name, "_pos"}, 128'(bus.rd_pos), 128'(0));
        chk({name, "_ram_data"}, 128'(bus.ram_data), 128'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.rd_start = 1'b0; bus.rd_stall = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = {3{32'hdeadbeef}};
        step(); step();
        chk_zero_outputs("reset");
        bus.wr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("wr_ready_after_reset", 128'(bus.wr_ready), 128'(1));
        step();

        // Preload every position, then count 5.
        for (int a = 1; a < PN; a++) do_write(AW'(a), {$urandom, $urandom, $urandom});
        do_write(8'd0, 96'd5);

        // Full stream with literal timing.
        start_read();
        wait_done(40, 1'b0);
        chk("full_first_valid_cyc", 128'(first_vld_cyc - start_cyc), 128'(6));
        chk("full_done_cyc", 128'(done_cyc - start_cyc), 128'(10));
        chk("full_beats", 128'(beats), 128'(5));
        chk("full_cell_count", 128'(bus.cell_count), 128'(5));
        chk("full_busy_after", 128'(bus.rd_busy), 128'(0));

        // rd_start while busy is ignored: exactly one stream of 5.
        start_read();
        step(); step();
        bus.rd_start = 1'b1; step(); bus.rd_start = 1'b0;
        wait_done(40, 1'b0);
        for (int i = 0; i < 12; i++) step();
        chk("ignored_start_beats", 128'(beats), 128'(5));

        // Empty cell.
        do_write(8'd0, 96'd0);
        start_read();
        wait_done(20, 1'b0);
        chk("empty_done_cyc", 128'(done_cyc - start_cyc), 128'(3));
        chk("empty_beats", 128'(beats), 128'(0));
        chk("empty_idle_cyc", 128'(cyc - start_cyc), 128'(4));
        chk("empty_busy", 128'(bus.rd_busy), 128'(0));

        // Stall in cycles 5..7 of a count-4 stream.
        do_write(8'd0, 96'd4);
        start_read();
        for (int i = 0; i < 4; i++) step();
        bus.rd_stall = 1'b1; win_on = 1'b1;
        step(); step(); step();
        bus.rd_stall = 1'b0; win_on = 1'b0;
        wait_done(40, 1'b0);
        chk("stall_no_issue", 128'(rden_win), 128'(0));
        chk("stall_beats", 128'(beats), 128'(4));
        chk("stall_first_valid_cyc", 128'(first_vld_cyc - start_cyc), 128'(6));
        chk("stall_done_cyc", 128'(done_cyc - start_cyc), 128'(12));

        // Write to address 0 collides with rd_start: write first, then stream of 3.
        bus.rd_start = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 8'd0; bus.wr_data = 96'd3;
        chk("collide_wr_ready", 128'(bus.wr_ready), 128'(1));
        ref_mem[0] = 96'd3;
        push_stream();
        arm();
        step();
        bus.rd_start = 1'b0; bus.wr_valid = 1'b0;
        chk("collide_wr_ready_next", 128'(bus.wr_ready), 128'(0));
        wait_done(40, 1'b0);
        chk("collide_beats", 128'(beats), 128'(3));
        chk("collide_cell_count", 128'(bus.cell_count), 128'(3));

        // Overflow: 250 clamps to 219 and the flag sticks.
        do_write(8'd0, 96'd250);
        chk("cnt_err_before", 128'(bus.cnt_err), 128'(0));
        start_read();
        wait_done(600, 1'b0);
        chk("ovf_cnt_err", 128'(bus.cnt_err), 128'(1));
        chk("ovf_cell_count", 128'(bus.cell_count), 128'(219));
        chk("ovf_beats", 128'(beats), 128'(219));
        do_write(8'd0, 96'd2);
        start_read();
        wait_done(40, 1'b0);
        chk("cnt_err_sticky", 128'(bus.cnt_err), 128'(1));
        chk("sticky_beats", 128'(beats), 128'(2));

        // Reset in the middle of a stream.
        do_write(8'd0, 96'd8);
        start_read();
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        exp_q.delete();
        exp_err = 1'b0;
        step(); step();
        rst_n = 1'b1;
        beats = 0;
        for (int i = 0; i < 6; i++) step();
        chk("postreset_beats", 128'(beats), 128'(0));
        chk("postreset_cell_count", 128'(bus.cell_count), 128'(0));
        chk("postreset_cnt_err", 128'(bus.cnt_err), 128'(0));
        chk("postreset_busy", 128'(bus.rd_busy), 128'(0));
        start_read();
        wait_done(60, 1'b0);
        chk("postreset_stream_beats", 128'(beats), 128'(8));
        chk("postreset_stream_count", 128'(bus.cell_count), 128'(8));

        // Randomized writes, counts and back-pressure.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                do_write(AW'($urandom_range(1, MAXC)), {$urandom, $urandom, $urandom});
            if ($urandom_range(0, 7) == 0) do_write(8'd0, DW'($urandom_range(200, 255)));
            else                           do_write(8'd0, DW'($urandom_range(0, 20)));
            start_read();
            wait_done(1200, 1'b1);
            step();
            chk("rnd_cell_count", 128'(bus.cell_count), 128'(exp_cnt));
            chk("rnd_cnt_err", 128'(bus.cnt_err), 128'(exp_err));
            chk("rnd_beats", 128'(beats), 128'(exp_cnt));
        end

        for (int i = 0; i < 5; i++) step();
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
